cdc_handshake_rx: RTL

CDC_HANDSHAKE_RX -- requirements
Module: cdc_handshake_rx

---
 rtl/cdc_handshake_rx.sv | 126 ++++++++++++
 1 files changed

// File: rtl/cdc_handshake_rx.sv
// -----------------------------------------------------------------------------
// cdc_handshake_rx
// Receive side of a 4-phase req/ack clock-domain crossing. The request from
// the source domain is synchronised into clk_b; the data bus is not
// synchronised. It is sampled once, on the capture edge, when the source is
// guaranteed to be holding it stable. The captured word is offered downstream
// with a valid/ready pair. The acknowledge goes back to the source only after
// downstream has taken the word. This gives end-to-end flow control without
// any storage beyond the single output register.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module cdc_handshake_rx #(
  parameter int DATA_W    = 8,   // width of the transferred word
  parameter int SYNC_SIZE = 2,   // request synchroniser depth, must be >= 2
  parameter int CNT_W     = 16   // width of the accepted-word counter
) (
  input  logic              clk_b,
  input  logic              rst_b_n,
  input  logic              req_a,
  input  logic [DATA_W-1:0] data_a,
  output logic              ack_b,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic              err
);

  // Handshake states:
  //   IDLE        - waiting for a synchronised request
  //   WAIT_RDY    - word captured, waiting for downstream to take it
  //   WAIT_REQ_LO - ack raised, waiting for the source to drop its request
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_RDY    = 2'd1,
    WAIT_REQ_LO = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  logic [SYNC_SIZE-1:0] req_sync_r;  // stage 0 is the only flop that sees req_a
  logic                 req_s;       // synchronised request
  state_e               state_r;
  logic                 accept_s;    // downstream takes the word on this edge

  assign req_s    = req_sync_r[SYNC_SIZE-1];
  assign accept_s = dout_valid & dout_ready;

  // Request synchroniser: a plain shift chain with no logic between stages.
  always_ff @(posedge clk_b or negedge rst_b_n) begin
    if (!rst_b_n) begin
      req_sync_r <= '0;
    end else begin
      req_sync_r <= {req_sync_r[SYNC_SIZE-2:0], req_a};
    end
  end

  // Handshake FSM: owns the capture register, valid, ack and the word counter.
  always_ff @(posedge clk_b or negedge rst_b_n) begin
    if (!rst_b_n) begin
      state_r    <= IDLE;
      ack_b      <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      xfer_cnt   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          // data_a is stable here: the source set it up before raising req_a,
          // and req_s lags req_a by the synchroniser depth.
          if (req_s) begin
            dout       <= data_a;
            dout_valid <= 1'b1;
            state_r    <= WAIT_RDY;
          end else begin
            state_r    <= IDLE;
          end
        end

        WAIT_RDY: begin
          // Hold the word indefinitely until downstream is ready. The ack is
          // deferred until then so the source cannot overrun the register.
          if (accept_s) begin
            dout_valid <= 1'b0;
            ack_b      <= 1'b1;
            xfer_cnt   <= xfer_cnt + CNT_ONE;
            state_r    <= WAIT_REQ_LO;
          end else begin
            state_r    <= WAIT_RDY;
          end
        end

        WAIT_REQ_LO: begin
          // Return-to-zero phase: keep ack high until the request is seen low.
          if (!req_s) begin
            ack_b   <= 1'b0;
            state_r <= IDLE;
          end else begin
            ack_b   <= 1'b1;
            state_r <= WAIT_REQ_LO;
          end
        end

        default: begin
          // Unreachable encoding: fall back to a clean idle without a word.
          ack_b      <= 1'b0;
          dout_valid <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  // Sticky protocol error: the source withdrew its request before it was acknowledged.
  always_ff @(posedge clk_b or negedge rst_b_n) begin
    if (!rst_b_n) begin
      err <= 1'b0;
    end else if ((state_r == WAIT_RDY) && !req_s) begin
      err <= 1'b1;
    end else begin
      err <= err;
    end
  end

endmodule
